// File: rtl/game_session_ctrl.sv
// game_session_ctrl: sequences countdown, timed/endless play and game-over hold for one session
module game_session_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int COUNTDOWN_S = 3,
  parameter int STAGE_COUNT = 3,
  parameter int STAGE_TIME_EASY = 30,
  parameter int STAGE_TIME_HARD = 20,
  parameter int OVER_HOLD_S = 2
) (
  input  logic        clock_100mhz,
  input  logic        reset,
  input  logic        start_game,
  input  logic        mode,
  input  logic        difficulty,
  input  logic        crash,
  input  logic        btnC,
  output logic        game_active,
  output logic        playing,
  output logic [2:0]  countdown,
  output logic [1:0]  stage,
  output logic [7:0]  time_left,
  output logic [13:0] score,
  output logic        game_over,
  output logic        win
);
  localparam int TW = $clog2(TICK_DIV + 1);
  typedef enum logic [1:0] {IDLE, COUNTDOWN, PLAYING, GAME_OVER} state_t;
  state_t state;
  logic [TW-1:0] tick_cnt;
  logic [7:0] hold;
  logic start_q, btn_q, mode_r, diff_r;
  logic sec_tick, start_rise, btn_rise;
  logic [14:0] score_sum;
  always_comb begin
    sec_tick = tick_cnt == TW'(TICK_DIV - 1);
    start_rise = start_game && !start_q;
    btn_rise = btnC && !btn_q;
    score_sum = {1'b0, score} + (diff_r ? 15'd2 : 15'd1);
  end
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tick_cnt <= '0;
      hold <= '0;
      start_q <= 1'b0;
      btn_q <= 1'b0;
      mode_r <= 1'b0;
      diff_r <= 1'b0;
      game_active <= 1'b0;
      playing <= 1'b0;
      countdown <= '0;
      stage <= '0;
      time_left <= '0;
      score <= '0;
      game_over <= 1'b0;
      win <= 1'b0;
    end else begin
      start_q <= start_game;
      btn_q <= btnC;
      tick_cnt <= sec_tick ? '0 : tick_cnt + TW'(1);
      case (state)
        IDLE:
          if (start_rise) begin
            state <= COUNTDOWN;
            tick_cnt <= '0;
            mode_r <= mode;
            diff_r <= difficulty;
            stage <= '0;
            score <= '0;
            countdown <= 3'(COUNTDOWN_S);
            game_active <= 1'b1;
          end
        COUNTDOWN:
          if (sec_tick) begin
            countdown <= countdown - 3'd1;
            if (countdown == 3'd1) begin
              state <= PLAYING;
              playing <= 1'b1;
              time_left <= mode_r ? 8'd0 : diff_r ? 8'(STAGE_TIME_HARD) : 8'(STAGE_TIME_EASY);
            end
          end
        PLAYING:
          if (crash) begin
            state <= GAME_OVER;
            tick_cnt <= '0;
            hold <= '0;
            playing <= 1'b0;
            game_over <= 1'b1;
            win <= 1'b0;
          end else if (sec_tick) begin
            score <= score_sum > 15'd9999 ? 14'd9999 : score_sum[13:0];
            if (!mode_r) begin
              time_left <= time_left - 8'd1;
              if (time_left == 8'd1) begin
                playing <= 1'b0;
                if (stage == 2'(STAGE_COUNT - 1)) begin
                  state <= GAME_OVER;
                  hold <= '0;
                  game_over <= 1'b1;
                  win <= 1'b1;
                end else begin
                  state <= COUNTDOWN;
                  stage <= stage + 2'd1;
                  countdown <= 3'(COUNTDOWN_S);
                end
              end
            end
          end
        GAME_OVER:
          if (hold == 8'(OVER_HOLD_S) && btn_rise) begin
            state <= IDLE;
            tick_cnt <= '0;
            game_active <= 1'b0;
            game_over <= 1'b0;
            win <= 1'b0;
            score <= '0;
            stage <= '0;
            time_left <= '0;
            countdown <= '0;
          end else if (sec_tick && hold != 8'(OVER_HOLD_S)) begin
            hold <= hold + 8'd1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
- Consumes the menu's start_game/mode/difficulty launch interface and produces the game_active acknowledgement.
- game_active returns the menu to its home page.
- Sequences one play session: pre-play countdown, timed stages (stage mode) or open-ended survival (endless mode), then a game-over hold and exit on btnC.
- Provides the pacing, stage, time and score state consumed by the gameplay and OLED renderers.

Parameters:
- TICK_DIV, 100_000_000: clock cycles per one-second tick; benches override it, e.g. 10.
- COUNTDOWN_S, 3: countdown length in seconds, range 1..7.
- STAGE_COUNT, 3: number of stages in stage mode, range 1..4.
- STAGE_TIME_EASY, 30: seconds per stage when difficulty=0.
- STAGE_TIME_HARD, 20: seconds per stage when difficulty=1.
- OVER_HOLD_S, 2: minimum seconds in GAME_OVER before btnC is accepted.

Ports:
- clock_100mhz, in, 1: system clock.
- reset, in, 1: asynchronous, active-high.
- start_game, in, 1: menu launch request. Level signal; held high until the menu returns home.
- mode, in, 1: 0 = stage, 1 = endless. Sampled only at launch.
- difficulty, in, 1: 0 = easy, 1 = hard. Sampled only at launch.
- crash, in, 1: one-cycle pulse from gameplay when the player fails.
- btnC, in, 1: centre button level, already debounced.
- game_active, out, 1: session in progress (COUNTDOWN, PLAYING or GAME_OVER).
- playing, out, 1: gameplay motion enable (PLAYING only).
- countdown, out, 3: seconds remaining in COUNTDOWN; 0 in all other states.
- stage, out, 2: current stage index, 0-based.
- time_left, out, 8: seconds remaining in the current stage. Stage mode only; 0 in endless mode.
- score, out, 14: session score, saturating at 9999.
- game_over, out, 1: high in GAME_OVER.
- win, out, 1: high in GAME_OVER when all stages were cleared.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0; state = IDLE.
- Reset asserted mid-session aborts immediately to IDLE, with all outputs 0.
- Second tick:
  - Counter runs 0..TICK_DIV-1 and emits sec_tick when it wraps.
  - Counter clears to 0 on every state transition, so every timed interval is exactly N*TICK_DIV cycles from entry.
- Edge detection: start_q and btn_q are registered copies of start_game and btnC. A rise is input=1 and copy=0.
- IDLE:
  - On a start_game rise: latch mode_r and diff_r; clear stage and score; set countdown=COUNTDOWN_S.
  - Go to COUNTDOWN. game_active becomes 1 on the next cycle (1-cycle latency).
  - A start_game level that is already high without a rise is ignored.
- COUNTDOWN:
  - Each sec_tick decrements countdown.
  - A sec_tick with countdown==1 → PLAYING, countdown=0.
  - On entry to PLAYING, time_left loads STAGE_TIME_EASY or STAGE_TIME_HARD per diff_r in stage mode, or 0 in endless mode.
- PLAYING:
  - playing=1.
  - Each sec_tick adds 1 (easy) or 2 (hard) to score, clamped at 9999.
  - Stage mode: each sec_tick decrements time_left. A sec_tick with time_left==1 ends the stage:
    - If stage==STAGE_COUNT-1 → GAME_OVER with win=1.
    - Otherwise stage increments, countdown reloads to COUNTDOWN_S, → COUNTDOWN.
  - Endless mode: time_left stays 0; only crash ends the session.
  - crash → GAME_OVER with win=0. crash and the stage-ending sec_tick in the same cycle: crash takes priority, so win=0.
- GAME_OVER:
  - game_active=1, game_over=1, playing=0.
  - score, stage and win are frozen.
  - btnC is ignored until OVER_HOLD_S sec_ticks have elapsed.
  - After that, a btnC rise → IDLE, with all outputs cleared the next cycle.
  - A btnC held high across the end of the hold does not count as a rise.
- Ignored inputs:
  - crash outside PLAYING is ignored.
  - start_game outside IDLE is ignored.
  - mode and difficulty changes after launch have no effect.

Test Plan (TICK_DIV=10, COUNTDOWN_S=3, STAGE_COUNT=2, STAGE_TIME_EASY=4, STAGE_TIME_HARD=2, OVER_HOLD_S=2):
- Launch latency: start_game rise with mode=0, difficulty=0 at cycle t. Required: game_active=1 and countdown=3 at t+1; playing=1 at t+31; time_left=4.
- Full stage win, easy: no crash. Required: stage 0→1 through a second 30-cycle countdown; GAME_OVER with win=1, score=8, stage=1.
- Endless hard with crash: mode=1, difficulty=1; crash pulse after 5 ticks in PLAYING. Required: score=10, time_left=0, game_over=1, win=0.
- Crash/tick collision: crash coincident with the final-stage time_left==1 sec_tick. Required: win=0.
- Exit gating: btnC pressed 5 cycles into GAME_OVER and held. Required: stays in GAME_OVER. Release and re-press after 20 cycles: IDLE, game_active=0 on the next cycle. start_game held high with no rise: no relaunch.
- Reset mid-PLAYING: reset pulse. Required: all outputs 0 asynchronously; a subsequent start_game rise relaunches normally with score=0.
